// File: rtl/rotor_stepper.sv
// Rotor stepping controller for a three-rotor cipher machine.
// A key press advances the rotors once (single carry plus double-step).
// The new positions are then held for a settle window, and step_done
// marks the cycle where the encrypted output path is valid.
module rotor_stepper #(
  parameter logic [4:0] NOTCH1        = 5'd16,
  parameter logic [4:0] NOTCH2        = 5'd4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [4:0] init_pos1,
  input  logic [4:0] init_pos2,
  input  logic [4:0] init_pos3,
  input  logic       step_req,
  output logic [4:0] position1,
  output logic [4:0] position2,
  output logic [4:0] position3,
  output logic       busy,
  output logic       step_done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STEP   = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] pos1_q, pos1_d;
  logic [4:0] pos2_q, pos2_d;
  logic [4:0] pos3_q, pos3_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Advance one ring position, wrapping Z back to A.
  function automatic logic [4:0] inc26(input logic [4:0] p);
    return (p == 5'd25) ? 5'd0 : 5'(p + 5'd1);
  endfunction

  // Fold out-of-range load values (26..31) back into 0..25.
  function automatic logic [4:0] fold26(input logic [4:0] p);
    return (p >= 5'd26) ? 5'(p - 5'd26) : p;
  endfunction

  // Next-state, position update and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos1_d  = pos1_q;
    pos2_d  = pos2_q;
    pos3_d  = pos3_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          pos1_d = fold26(init_pos1);
          pos2_d = fold26(init_pos2);
          pos3_d = fold26(init_pos3);
        end else if (step_req) begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        // Notches are evaluated on the pre-step positions.
        pos1_d = inc26(pos1_q);
        if ((pos1_q == NOTCH1) || (pos2_q == NOTCH2)) begin
          pos2_d = inc26(pos2_q);
        end
        if (pos2_q == NOTCH2) begin
          pos3_d = inc26(pos3_q);
        end
        cnt_d   = 4'd0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d = 4'(cnt_q + 4'd1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, positions and status flags; reset aborts any step in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      pos1_q  <= 5'd0;
      pos2_q  <= 5'd0;
      pos3_q  <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos1_q  <= pos1_d;
      pos2_q  <= pos2_d;
      pos3_q  <= pos3_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign position1 = pos1_q;
  assign position2 = pos2_q;
  assign position3 = pos3_q;
  assign busy      = busy_q;
  assign step_done = done_q;

endmodule
